instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Fetch stage of the 14-bit-instruction pipelined core; master of the program ROM read interface.
- Drives the 11-bit ROM address and captures the combinational 14-bit ROM word into the instruction register (IR) for the execute stage.
- Resolves GOTO/CALL/RETURN locally in the fetch cycle (zero-bubble) using an internal hardware return stack.
- Accepts stall, skip-flush and computed-redirect requests from execute.

Parameters:
- ADDR_W, 11, program address width
- INSTR_W, 14, instruction width
- STACK_DEPTH, 8, return stack entries (power of two)
- RESET_VEC, 11'h000, PC value after reset

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous active-high reset
- Rom_addr_out  output  ADDR_W  ROM read address, equal to PC (combinational from the PC register)
- Rom_data_in  input  INSTR_W  ROM word at Rom_addr_out, valid in the same cycle
- stall_in  input  1  hold the fetch state this cycle
- flush_in  input  1  discard the word being fetched this cycle (skip)
- redirect_valid_in  input  1  execute-computed jump request
- redirect_addr_in  input  ADDR_W  jump target
- IR_out  output  INSTR_W  fetched instruction for execute
- IR_pc_out  output  ADDR_W  address IR_out was fetched from
- IR_valid_out  output  1  IR_out holds a real instruction (0 means bubble/NOP)
- stack_overflow_out  output  1  sticky flag: push while full
- stack_underflow_out  output  1  sticky flag: pop while empty

Behaviour:
- Reset (rst=1 at a clk edge): PC=RESET_VEC, IR_out=14'h0000, IR_pc_out=0, IR_valid_out=0, SP=0, count=0, both flags 0. Reset overrides all other inputs.
- Local decode of Rom_data_in:
  - GOTO: [13:11]=3'b101
  - CALL: [13:11]=3'b100
  - RETURN: word==14'h0008
  - target k=[10:0]
- Per-edge priority: rst > redirect_valid_in > stall_in > flush_in > normal.
- Redirect:
  - PC<=redirect_addr_in; IR<=0; IR_valid<=0.
  - Fetched word is not decoded; stack unchanged.
  - Wins over a simultaneous stall.
- Stall: PC, IR, IR_pc, IR_valid, stack and flags all hold; no push/pop.
- Flush:
  - IR<=0; IR_valid<=0; PC<=PC+1.
  - Fetched word is not decoded, so a skipped CALL/GOTO/RETURN has no effect.
- Normal: IR<=Rom_data_in; IR_pc<=PC; IR_valid<=1; then:
  - GOTO: PC<=k.
  - CALL: push PC+1; PC<=k.
  - RETURN: PC<=pop.
  - otherwise PC<=PC+1.
- Latency: ROM word appears on IR_out one cycle after its address is on Rom_addr_out. Taken GOTO/CALL/RETURN incur no bubble.
- Arithmetic: PC+1 is modulo 2^ADDR_W (11'h7FF -> 11'h000), including the CALL return address.
- Return stack: circular, STACK_DEPTH entries, write pointer SP, occupancy count 0..STACK_DEPTH.
  - Push writes mem[SP]; SP<=SP+1 mod depth; count<=min(count+1,DEPTH).
  - Push with count==DEPTH overwrites the oldest entry and sets stack_overflow_out.
  - Pop reads mem[SP-1]; SP<=SP-1 mod depth; count<=max(count-1,0).
  - Pop with count==0 still returns mem[SP-1] and sets stack_underflow_out.
  - Flags clear only on rst.
- Only one push or pop can occur per cycle, because a word is exactly one of CALL or RETURN.
- Reset mid-CALL: push is discarded and PC=RESET_VEC.

Decomposition:
- Shared package core_pkg holds:
  - ADDR_W, INSTR_W
  - OP_GOTO_HI=3'b101, OP_CALL_HI=3'b100, INSTR_RETURN=14'h0008, INSTR_NOP=14'h0000
  - an is_goto/is_call/is_return decode function shared with the execute decoder
- One sub-module: return_stack (push, pop, push_data, pop_data, overflow, underflow; synchronous rst).
- PC/IR logic stays in instr_fetch_unit.

Test Plan:
- Reset then free-run over ROM words 0:3003, 1:00A3, 2:00A7 -> Rom_addr_out 0,1,2; IR_out 3003 @c1, 00A3 @c2 with IR_pc_out 0,1; IR_valid_out=0 @c0.
- CALL at 0x14 (14'h2021), RETURN at 0x24 (14'h0008) -> Rom_addr_out goes 0x14->0x21 with no bubble; after RETURN fetched, Rom_addr_out=0x15; count back to 0; no flags.
- GOTO 14'h2800|0x7FF at 0x10 -> PC=0x7FF; next non-branch word -> PC wraps to 0x000.
- flush_in=1 while Rom_data_in=14'h2021 -> IR_out=0000, IR_valid_out=0, PC=previous+1, stack count unchanged.
- stall_in=1 for 3 cycles -> Rom_addr_out, IR_out and IR_pc_out constant; redirect_valid_in=1 addr 0x100 with stall_in=1 -> PC=0x100, IR_valid_out=0.
- Nine nested CALLs -> stack_overflow_out=1 after the 9th; nine RETURNs -> the 9th sets stack_underflow_out=1; rst clears both flags and sets PC=0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: datapath widths, branch opcodes and the branch
// decode helpers used by both fetch and execute.
package core_pkg;
  localparam int ADDR_W  = 11;
  localparam int INSTR_W = 14;

  localparam logic [2:0]         OP_GOTO_HI   = 3'b101;
  localparam logic [2:0]         OP_CALL_HI   = 3'b100;
  localparam logic [INSTR_W-1:0] INSTR_RETURN = 14'h0008;
  localparam logic [INSTR_W-1:0] INSTR_NOP    = 14'h0000;

  function automatic logic is_goto(input logic [INSTR_W-1:0] w);
    return w[INSTR_W-1 -: 3] == OP_GOTO_HI;
  endfunction

  function automatic logic is_call(input logic [INSTR_W-1:0] w);
    return w[INSTR_W-1 -: 3] == OP_CALL_HI;
  endfunction

  function automatic logic is_return(input logic [INSTR_W-1:0] w);
    return w == INSTR_RETURN;
  endfunction
endpackage

// File: rtl/return_stack.sv
// Circular hardware return stack. Pushing when full overwrites the oldest
// entry; popping when empty still returns mem[sp-1]. Both raise sticky flags.
module return_stack #(
  parameter int DEPTH = 8,
  parameter int W     = 11
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             push_data,
  output logic [W-1:0]             pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] sp, sp_m1;

  assign sp_m1    = sp - PW'(1);
  assign pop_data = mem[sp_m1];

  // Storage needs no reset; occupancy tracking decides what is meaningful.
  always_ff @(posedge clk)
    if (!rst && push) mem[sp] <= push_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      sp        <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (push) begin
      sp <= sp + PW'(1);
      if (count == FULL) overflow <= 1'b1;
      else               count    <= count + (PW+1)'(1);
    end else if (pop) begin
      sp <= sp_m1;
      if (count == '0) underflow <= 1'b1;
      else             count     <= count - (PW+1)'(1);
    end
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: drives the ROM address from PC, registers the ROM word into IR
// and resolves GOTO/CALL/RETURN in the fetch cycle so taken branches cost no bubble.
module instr_fetch_unit #(
  parameter int              ADDR_W      = 11,
  parameter int              INSTR_W     = 14,
  parameter int              STACK_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  Rom_addr_out,
  input  logic [INSTR_W-1:0] Rom_data_in,
  input  logic               stall_in,
  input  logic               flush_in,
  input  logic               redirect_valid_in,
  input  logic [ADDR_W-1:0]  redirect_addr_in,
  output logic [INSTR_W-1:0] IR_out,
  output logic [ADDR_W-1:0]  IR_pc_out,
  output logic               IR_valid_out,
  output logic               stack_overflow_out,
  output logic               stack_underflow_out
);
  import core_pkg::*;

  logic [ADDR_W-1:0] pc, pc_inc, pc_next, pop_data;
  logic              fetch_ok, w_goto, w_call, w_ret, push, pop;
  logic [$clog2(STACK_DEPTH):0] count;

  assign Rom_addr_out = pc;
  assign pc_inc       = pc + ADDR_W'(1);

  // The word is only decoded when it will actually be issued to execute.
  assign fetch_ok = !redirect_valid_in && !stall_in && !flush_in;
  assign w_goto   = is_goto(Rom_data_in);
  assign w_call   = is_call(Rom_data_in);
  assign w_ret    = is_return(Rom_data_in);
  assign push     = fetch_ok && w_call;
  assign pop      = fetch_ok && w_ret;

  always_comb begin
    pc_next = pc_inc;
    if (w_goto || w_call) pc_next = Rom_data_in[ADDR_W-1:0];
    else if (w_ret)       pc_next = pop_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc           <= RESET_VEC;
      IR_out       <= INSTR_NOP;
      IR_pc_out    <= '0;
      IR_valid_out <= 1'b0;
    end else if (redirect_valid_in) begin
      pc           <= redirect_addr_in;
      IR_out       <= INSTR_NOP;
      IR_valid_out <= 1'b0;
    end else if (stall_in) begin
      pc <= pc;
    end else if (flush_in) begin
      pc           <= pc_inc;
      IR_out       <= INSTR_NOP;
      IR_valid_out <= 1'b0;
    end else begin
      pc           <= pc_next;
      IR_out       <= Rom_data_in;
      IR_pc_out    <= pc;
      IR_valid_out <= 1'b1;
    end
  end

  return_stack #(.DEPTH(STACK_DEPTH), .W(ADDR_W)) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .pop_data  (pop_data),
    .count     (count),
    .overflow  (stack_overflow_out),
    .underflow (stack_underflow_out)
  );
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a combinational ROM model.
module tb_instr_fetch_unit;
  logic        clk = 0;
  logic        rst = 1;
  logic [10:0] Rom_addr_out;
  logic [13:0] Rom_data_in;
  logic        stall_in = 0, flush_in = 0, redirect_valid_in = 0;
  logic [10:0] redirect_addr_in = '0;
  logic [13:0] IR_out;
  logic [10:0] IR_pc_out;
  logic        IR_valid_out, stack_overflow_out, stack_underflow_out;

  logic [13:0] rom [2048];
  int cmps = 0, errs = 0;

  assign Rom_data_in = rom[Rom_addr_out];

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk(clk), .rst(rst),
    .Rom_addr_out(Rom_addr_out), .Rom_data_in(Rom_data_in),
    .stall_in(stall_in), .flush_in(flush_in),
    .redirect_valid_in(redirect_valid_in), .redirect_addr_in(redirect_addr_in),
    .IR_out(IR_out), .IR_pc_out(IR_pc_out), .IR_valid_out(IR_valid_out),
    .stack_overflow_out(stack_overflow_out), .stack_underflow_out(stack_underflow_out)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic jump(input logic [10:0] a);
    redirect_valid_in = 1; redirect_addr_in = a;
    tick();
    redirect_valid_in = 0;
  endtask

  task automatic test_reset();
    rom[0] = 14'h3003; rom[1] = 14'h00A3; rom[2] = 14'h00A7;
    rst = 1; tick(); rst = 0;
    cmps++; if (Rom_addr_out !== 11'h000) begin errs++; $display("FAIL reset_addr got %h exp 000", Rom_addr_out); end
    cmps++; if (IR_valid_out !== 1'b0) begin errs++; $display("FAIL reset_valid got %b exp 0", IR_valid_out); end
    cmps++; if (IR_out !== 14'h0000) begin errs++; $display("FAIL reset_ir got %h exp 0000", IR_out); end
    cmps++; if ({stack_overflow_out, stack_underflow_out} !== 2'b00) begin errs++; $display("FAIL reset_flags got %b%b exp 00", stack_overflow_out, stack_underflow_out); end
    tick();
    cmps++; if (IR_out !== 14'h3003 || IR_pc_out !== 11'h000 || IR_valid_out !== 1'b1) begin errs++; $display("FAIL c1_ir got %h/%h/%b exp 3003/000/1", IR_out, IR_pc_out, IR_valid_out); end
    cmps++; if (Rom_addr_out !== 11'h001) begin errs++; $display("FAIL c1_addr got %h exp 001", Rom_addr_out); end
    tick();
    cmps++; if (IR_out !== 14'h00A3 || IR_pc_out !== 11'h001) begin errs++; $display("FAIL c2_ir got %h/%h exp 00a3/001", IR_out, IR_pc_out); end
    cmps++; if (Rom_addr_out !== 11'h002) begin errs++; $display("FAIL c2_addr got %h exp 002", Rom_addr_out); end
  endtask

  task automatic test_call_return();
    rom[11'h14] = 14'h2021; rom[11'h24] = 14'h0008;
    jump(11'h014);
    cmps++; if (Rom_addr_out !== 11'h014 || IR_valid_out !== 1'b0) begin errs++; $display("FAIL redir_14 got %h/%b exp 014/0", Rom_addr_out, IR_valid_out); end
    tick();
    cmps++; if (Rom_addr_out !== 11'h021 || IR_out !== 14'h2021 || IR_valid_out !== 1'b1) begin errs++; $display("FAIL call got %h/%h/%b exp 021/2021/1", Rom_addr_out, IR_out, IR_valid_out); end
    cmps++; if (dut.u_stack.count !== 4'd1) begin errs++; $display("FAIL call_count got %0d exp 1", dut.u_stack.count); end
    repeat (3) tick();
    cmps++; if (Rom_addr_out !== 11'h024) begin errs++; $display("FAIL pre_ret got %h exp 024", Rom_addr_out); end
    tick();
    cmps++; if (Rom_addr_out !== 11'h015 || IR_out !== 14'h0008 || IR_pc_out !== 11'h024) begin errs++; $display("FAIL ret got %h/%h/%h exp 015/0008/024", Rom_addr_out, IR_out, IR_pc_out); end
    cmps++; if (dut.u_stack.count !== 4'd0 || stack_overflow_out !== 1'b0 || stack_underflow_out !== 1'b0) begin errs++; $display("FAIL ret_stack got %0d/%b/%b exp 0/0/0", dut.u_stack.count, stack_overflow_out, stack_underflow_out); end
  endtask

  task automatic test_goto_wrap();
    rom[11'h10] = 14'h2FFF; rom[11'h7FF] = 14'h0000;
    jump(11'h010);
    tick();
    cmps++; if (Rom_addr_out !== 11'h7FF) begin errs++; $display("FAIL goto got %h exp 7ff", Rom_addr_out); end
    tick();
    cmps++; if (Rom_addr_out !== 11'h000 || IR_pc_out !== 11'h7FF) begin errs++; $display("FAIL wrap got %h/%h exp 000/7ff", Rom_addr_out, IR_pc_out); end
  endtask

  task automatic test_flush();
    rom[11'h30] = 14'h2021;
    jump(11'h030);
    flush_in = 1; tick(); flush_in = 0;
    cmps++; if (IR_out !== 14'h0000 || IR_valid_out !== 1'b0 || Rom_addr_out !== 11'h031) begin errs++; $display("FAIL flush got %h/%b/%h exp 0000/0/031", IR_out, IR_valid_out, Rom_addr_out); end
    cmps++; if (dut.u_stack.count !== 4'd0) begin errs++; $display("FAIL flush_count got %0d exp 0", dut.u_stack.count); end
  endtask

  task automatic test_stall();
    rom[11'h40] = 14'h1234;
    jump(11'h040);
    tick();
    stall_in = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      cmps++; if (Rom_addr_out !== 11'h041 || IR_out !== 14'h1234 || IR_pc_out !== 11'h040 || IR_valid_out !== 1'b1) begin
        errs++; $display("FAIL stall%0d got %h/%h/%h/%b exp 041/1234/040/1", i, Rom_addr_out, IR_out, IR_pc_out, IR_valid_out); end
    end
    jump(11'h100);
    stall_in = 0;
    cmps++; if (Rom_addr_out !== 11'h100 || IR_valid_out !== 1'b0) begin errs++; $display("FAIL stall_redir got %h/%b exp 100/0", Rom_addr_out, IR_valid_out); end
  endtask

  task automatic test_overflow_underflow();
    logic [10:0] exp_pc;
    for (int i = 0; i < 9; i++) rom[11'h200 + i] = 14'h2000 | 14'(11'h201 + i);
    rom[11'h300] = 14'h0008;
    jump(11'h200);
    repeat (8) tick();
    cmps++; if (stack_overflow_out !== 1'b0 || dut.u_stack.count !== 4'd8) begin errs++; $display("FAIL ovf8 got %b/%0d exp 0/8", stack_overflow_out, dut.u_stack.count); end
    tick();
    cmps++; if (stack_overflow_out !== 1'b1 || Rom_addr_out !== 11'h209) begin errs++; $display("FAIL ovf9 got %b/%h exp 1/209", stack_overflow_out, Rom_addr_out); end
    // 9th push overwrote the oldest slot with 0x209; the 9th pop wraps back onto it.
    for (int i = 0; i < 9; i++) begin
      jump(11'h300);
      tick();
      exp_pc = (i == 0 || i == 8) ? 11'h209 : 11'h209 - 11'(i);
      cmps++; if (Rom_addr_out !== exp_pc) begin errs++; $display("FAIL pop%0d got %h exp %h", i, Rom_addr_out, exp_pc); end
      if (i == 7) begin
        cmps++; if (stack_underflow_out !== 1'b0) begin errs++; $display("FAIL unf8 got %b exp 0", stack_underflow_out); end
      end
    end
    cmps++; if (stack_underflow_out !== 1'b1) begin errs++; $display("FAIL unf9 got %b exp 1", stack_underflow_out); end
    jump(11'h014);
    rst = 1; tick(); rst = 0;
    cmps++; if (Rom_addr_out !== 11'h000 || dut.u_stack.count !== 4'd0) begin errs++; $display("FAIL rst_call got %h/%0d exp 000/0", Rom_addr_out, dut.u_stack.count); end
    cmps++; if ({stack_overflow_out, stack_underflow_out} !== 2'b00) begin errs++; $display("FAIL rst_flags got %b%b exp 00", stack_overflow_out, stack_underflow_out); end
  endtask

  initial begin
    for (int a = 0; a < 2048; a++) rom[a] = 14'h0000;
    test_reset();
    test_call_return();
    test_goto_wrap();
    test_flush();
    test_stall();
    test_overflow_underflow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end
endmodule
